// File: rtl/serin_pkg.sv
// Shared types and defaults for the serial byte-to-word front ends.
package serin_pkg;

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    HOLD
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/serin_timeout.sv
// Saturating idle counter: counts enabled cycles, clears on demand and flags
// the cycle in which the count would reach LIMIT. LIMIT = 0 disables expiry.
module serin_timeout #(
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] count;

  // Clear beats expiry, so an event arriving in the limit cycle always wins.
  assign expire = (LIMIT > 0) && en && !clr && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || expire) begin
      count <= '0;
    end else if (en && (count != TOP)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serin_word.sv
// Assembles received bytes into WORD_BYTES-wide words with optional sync-byte
// framing and inter-byte timeout, presented on a valid/ready handshake.
module serin_word
  import serin_pkg::*;
#(
  parameter int         WORD_BYTES     = 16,
  parameter bit         MSB_FIRST      = 1'b1,
  parameter bit         SYNC_EN        = 1'b0,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_valid,
  input  logic [7:0]                        rx_data,
  output logic [8*WORD_BYTES-1:0]           word_out,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic                              overrun,
  input  logic                              overrun_clr,
  output logic                              timeout,
  output logic [$clog2(WORD_BYTES+1)-1:0]   byte_cnt
);

  localparam int              CW       = $clog2(WORD_BYTES + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WORD_BYTES - 1);
  localparam state_t          START    = SYNC_EN ? HUNT : COLLECT;

  state_t                  state, state_n;
  logic [8*WORD_BYTES-1:0] shadow, shadow_n, word_n;
  logic [CW-1:0]           cnt_n;
  logic                    valid_n, overrun_n, timeout_n;
  logic                    active, expire;

  // Places byte b into slot idx, honouring the configured byte order.
  function automatic logic [8*WORD_BYTES-1:0] put_byte(
    input logic [8*WORD_BYTES-1:0] w,
    input logic [CW-1:0]           idx,
    input logic [7:0]              b
  );
    logic [8*WORD_BYTES-1:0] r;
    r = w;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (idx == CW'(k)) begin
        r[8*(MSB_FIRST ? (WORD_BYTES - 1 - k) : k) +: 8] = b;
      end
    end
    return r;
  endfunction

  // Idle time only matters while a partial word is pending.
  assign active = (state == COLLECT) && (byte_cnt != '0);

  serin_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .en    (active),
    .clr   (rx_valid || !active),
    .expire(expire)
  );

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    word_n    = word_out;
    valid_n   = word_valid;
    cnt_n     = byte_cnt;
    overrun_n = overrun;
    timeout_n = 1'b0;
    case (state)
      HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_n = COLLECT;
          cnt_n   = '0;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          shadow_n = put_byte(shadow, byte_cnt, rx_data);
          if (byte_cnt == LAST_CNT) begin
            word_n   = shadow_n;
            valid_n  = 1'b1;
            cnt_n    = '0;
            shadow_n = '0;
            state_n  = HOLD;
          end else begin
            cnt_n = byte_cnt + CW'(1);
          end
        end else if (expire) begin
          shadow_n  = '0;
          cnt_n     = '0;
          timeout_n = 1'b1;
          state_n   = START;
        end
      end
      HOLD: begin
        // A byte arriving with the handshake opens the next frame.
        if (word_ready) begin
          valid_n = 1'b0;
          state_n = START;
          if (rx_valid) begin
            if (SYNC_EN) begin
              if (rx_data == SYNC_BYTE) state_n = COLLECT;
            end else begin
              shadow_n = put_byte('0, '0, rx_data);
              cnt_n    = CW'(1);
              state_n  = COLLECT;
            end
          end
        end else if (rx_valid) begin
          overrun_n = 1'b1;
        end
      end
      default: state_n = START;
    endcase
    if (overrun_clr) overrun_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= START;
      shadow     <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      byte_cnt   <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      word_out   <= word_n;
      word_valid <= valid_n;
      byte_cnt   <= cnt_n;
      overrun    <= overrun_n;
      timeout    <= timeout_n;
    end
  end

endmodule

// File: tb/tb_serin_word.sv
// Self-checking bench for serin_word: five parameter variants, expected words
// are queued as bytes are driven and popped when each word is accepted.
`timescale 1ns/1ps
module tb_serin_word;

  typedef struct {
    int           inst;
    logic [127:0] w;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   rx_valid, word_ready, overrun_clr;
  logic [4:0]   word_valid, overrun, timeout;
  logic [7:0]   rx_data [5];
  logic [127:0] word [5];
  logic [7:0]   cnt [5];

  logic [127:0] wo_a;
  logic [31:0]  wo_b, wo_d;
  logic [15:0]  wo_c, wo_e;
  logic [4:0]   bc_a;
  logic [2:0]   bc_b, bc_d;
  logic [1:0]   bc_c, bc_e;

  exp_t exp_q[$];
  int   passed;
  int   total;

  always #5 clk = ~clk;

  serin_word dut_a (
    .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
    .word_out(wo_a), .word_valid(word_valid[0]), .word_ready(word_ready[0]),
    .overrun(overrun[0]), .overrun_clr(overrun_clr[0]), .timeout(timeout[0]),
    .byte_cnt(bc_a));

  serin_word #(.WORD_BYTES(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
    .word_out(wo_b), .word_valid(word_valid[1]), .word_ready(word_ready[1]),
    .overrun(overrun[1]), .overrun_clr(overrun_clr[1]), .timeout(timeout[1]),
    .byte_cnt(bc_b));

  serin_word #(.WORD_BYTES(2), .SYNC_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .rx_valid(rx_valid[2]), .rx_data(rx_data[2]),
    .word_out(wo_c), .word_valid(word_valid[2]), .word_ready(word_ready[2]),
    .overrun(overrun[2]), .overrun_clr(overrun_clr[2]), .timeout(timeout[2]),
    .byte_cnt(bc_c));

  serin_word #(.WORD_BYTES(4), .TIMEOUT_CYCLES(10)) dut_d (
    .clk(clk), .rst(rst), .rx_valid(rx_valid[3]), .rx_data(rx_data[3]),
    .word_out(wo_d), .word_valid(word_valid[3]), .word_ready(word_ready[3]),
    .overrun(overrun[3]), .overrun_clr(overrun_clr[3]), .timeout(timeout[3]),
    .byte_cnt(bc_d));

  serin_word #(.WORD_BYTES(2)) dut_e (
    .clk(clk), .rst(rst), .rx_valid(rx_valid[4]), .rx_data(rx_data[4]),
    .word_out(wo_e), .word_valid(word_valid[4]), .word_ready(word_ready[4]),
    .overrun(overrun[4]), .overrun_clr(overrun_clr[4]), .timeout(timeout[4]),
    .byte_cnt(bc_e));

  assign word[0] = wo_a;
  assign word[1] = {96'b0, wo_b};
  assign word[2] = {112'b0, wo_c};
  assign word[3] = {96'b0, wo_d};
  assign word[4] = {112'b0, wo_e};
  assign cnt[0]  = {3'b0, bc_a};
  assign cnt[1]  = {5'b0, bc_b};
  assign cnt[2]  = {6'b0, bc_c};
  assign cnt[3]  = {5'b0, bc_d};
  assign cnt[4]  = {6'b0, bc_e};

  task automatic check_output(input string tag, input logic [127:0] got,
                              input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int i, input logic [7:0] b);
    rx_data[i]  = b;
    rx_valid[i] = 1'b1;
    @(negedge clk);
    rx_valid[i] = 1'b0;
  endtask

  task automatic push_word(input int i, input logic [127:0] w);
    exp_t e;
    e.inst = i;
    e.w    = w;
    exp_q.push_back(e);
  endtask

  task automatic pop_and_check(input int i, input string tag);
    exp_t e;
    check_output({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_output({tag, "_sb_inst"}, 128'(i), 128'(e.inst));
      check_output({tag, "_word"}, word[i], e.w);
    end
  endtask

  // Waits (bounded) for a word, checks it against the scoreboard, accepts it.
  task automatic accept_word(input int i, input string tag);
    int n;
    n = 0;
    while (!word_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_valid"}, 128'(word_valid[i]), 128'd1);
    pop_and_check(i, tag);
    word_ready[i] = 1'b1;
    @(negedge clk);
    word_ready[i] = 1'b0;
    check_output({tag, "_released"}, 128'(word_valid[i]), 128'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    passed      = 0;
    total       = 0;
    rst         = 1'b0;
    rx_valid    = '0;
    word_ready  = '0;
    overrun_clr = '0;
    for (int i = 0; i < 5; i++) rx_data[i] = 8'h00;
    idle(3);
    check_output("rst_valid", 128'(word_valid), 128'd0);
    check_output("rst_word_a", word[0], 128'd0);
    check_output("rst_cnt_a", 128'(cnt[0]), 128'd0);
    check_output("rst_overrun", 128'(overrun), 128'd0);
    check_output("rst_timeout", 128'(timeout), 128'd0);
    rst = 1'b1;
    idle(1);

    $display("[TB] test 1: 16-byte MSB-first word");
    push_word(0, 128'h000102030405060708090A0B0C0D0E0F);
    for (int k = 0; k < 15; k++) send_byte(0, 8'(k));
    check_output("t1_cnt15", 128'(cnt[0]), 128'd15);
    check_output("t1_not_yet", 128'(word_valid[0]), 128'd0);
    send_byte(0, 8'h0F);
    check_output("t1_valid_1cyc", 128'(word_valid[0]), 128'd1);
    check_output("t1_word", word[0], 128'h000102030405060708090A0B0C0D0E0F);
    check_output("t1_cnt0", 128'(cnt[0]), 128'd0);
    idle(5);
    check_output("t1_stable", word[0], 128'h000102030405060708090A0B0C0D0E0F);
    check_output("t1_still_valid", 128'(word_valid[0]), 128'd1);
    accept_word(0, "t1");

    $display("[TB] test 2: LSB-first 4-byte words back to back");
    push_word(1, 128'h44332211);
    send_byte(1, 8'h11); send_byte(1, 8'h22); send_byte(1, 8'h33); send_byte(1, 8'h44);
    accept_word(1, "t2a");
    push_word(1, 128'h88776655);
    send_byte(1, 8'h55); send_byte(1, 8'h66); send_byte(1, 8'h77); send_byte(1, 8'h88);
    accept_word(1, "t2b");

    $display("[TB] test 3: sync framing");
    push_word(2, 128'h1234);
    send_byte(2, 8'h00);
    check_output("t3_hunt_cnt", 128'(cnt[2]), 128'd0);
    send_byte(2, 8'hA5);
    send_byte(2, 8'h12);
    check_output("t3_cnt1", 128'(cnt[2]), 128'd1);
    send_byte(2, 8'h34);
    accept_word(2, "t3");
    send_byte(2, 8'h56); send_byte(2, 8'h78);
    idle(2);
    check_output("t3_nosync_valid", 128'(word_valid[2]), 128'd0);
    check_output("t3_nosync_cnt", 128'(cnt[2]), 128'd0);

    $display("[TB] test 4: inter-byte timeout");
    send_byte(3, 8'hAA); send_byte(3, 8'hBB);
    check_output("t4_cnt2", 128'(cnt[3]), 128'd2);
    idle(9);
    check_output("t4_before_limit", 128'(timeout[3]), 128'd0);
    check_output("t4_before_cnt", 128'(cnt[3]), 128'd2);
    idle(1);
    check_output("t4_pulse", 128'(timeout[3]), 128'd1);
    check_output("t4_cnt_cleared", 128'(cnt[3]), 128'd0);
    idle(1);
    check_output("t4_pulse_end", 128'(timeout[3]), 128'd0);
    push_word(3, 128'hCCDDEEFF);
    send_byte(3, 8'hCC);
    idle(9);
    send_byte(3, 8'hDD);
    check_output("t4_rx_wins", 128'(timeout[3]), 128'd0);
    check_output("t4_rx_wins_cnt", 128'(cnt[3]), 128'd2);
    send_byte(3, 8'hEE); send_byte(3, 8'hFF);
    accept_word(3, "t4");

    $display("[TB] test 5: overrun while holding");
    push_word(4, 128'h0102);
    send_byte(4, 8'h01); send_byte(4, 8'h02);
    check_output("t5_valid", 128'(word_valid[4]), 128'd1);
    check_output("t5_no_overrun", 128'(overrun[4]), 128'd0);
    send_byte(4, 8'h03);
    check_output("t5_overrun", 128'(overrun[4]), 128'd1);
    check_output("t5_word_kept", word[4], 128'h0102);
    overrun_clr[4] = 1'b1;
    idle(1);
    overrun_clr[4] = 1'b0;
    check_output("t5_cleared", 128'(overrun[4]), 128'd0);
    overrun_clr[4] = 1'b1;
    rx_data[4]     = 8'h04;
    rx_valid[4]    = 1'b1;
    idle(1);
    overrun_clr[4] = 1'b0;
    rx_valid[4]    = 1'b0;
    check_output("t5_clr_wins", 128'(overrun[4]), 128'd0);
    check_output("t5_word_still", word[4], 128'h0102);
    accept_word(4, "t5");

    $display("[TB] test 6: handshake with same-cycle byte, then reset");
    push_word(4, 128'h0506);
    send_byte(4, 8'h05); send_byte(4, 8'h06);
    check_output("t6_held", 128'(word_valid[4]), 128'd1);
    pop_and_check(4, "t6a");
    word_ready[4] = 1'b1;
    rx_data[4]    = 8'h07;
    rx_valid[4]   = 1'b1;
    idle(1);
    word_ready[4] = 1'b0;
    rx_valid[4]   = 1'b0;
    check_output("t6_released", 128'(word_valid[4]), 128'd0);
    check_output("t6_cnt1", 128'(cnt[4]), 128'd1);
    check_output("t6_no_overrun", 128'(overrun[4]), 128'd0);
    push_word(4, 128'h0708);
    send_byte(4, 8'h08);
    accept_word(4, "t6b");

    send_byte(4, 8'h09); send_byte(4, 8'h0A);
    send_byte(0, 8'h21); send_byte(0, 8'h22); send_byte(0, 8'h23);
    check_output("t6_pre_rst_valid", 128'(word_valid[4]), 128'd1);
    check_output("t6_pre_rst_cnt", 128'(cnt[0]), 128'd3);
    #2 rst = 1'b0;
    #1;
    check_output("t6_rst_valid", 128'(word_valid[4]), 128'd0);
    check_output("t6_rst_word", word[4], 128'd0);
    check_output("t6_rst_cnt", 128'(cnt[0]), 128'd0);
    idle(1);
    rst = 1'b1;
    idle(2);
    check_output("t6_post_rst_valid", 128'(word_valid), 128'd0);

    check_output("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
